// File: rtl/div_if.sv
// rtl/div_if.sv - execute-stage operand/operation bus shared by the divider and its pipeline driver.
// iType_e lives at compilation-unit scope so the divider and the pipeline side see one definition.
typedef enum logic [3:0] {
  OP_NOP,
  OP_ADD,
  OP_SUB,
  OP_MUL,
  OP_MULH,
  DIV,
  DIVU,
  REM,
  REMU
} iType_e;

interface div_if;
  logic [31:0] first_operand_i;
  logic [31:0] second_operand_i;
  iType_e      instruction_operation_i;
  logic        hold_o;
  logic [31:0] div_result_o;

  modport master (
    output first_operand_i, second_operand_i, instruction_operation_i,
    input  hold_o, div_result_o
  );

  modport slave (
    input  first_operand_i, second_operand_i, instruction_operation_i,
    output hold_o, div_result_o
  );
endinterface

// File: rtl/div.sv
// rtl/div.sv - iterative radix-2 RV32M divider (DIV/DIVU/REM/REMU), one quotient bit per cycle.
// Optional macro DIV_EARLY_OUT_EN: single-cycle completion for divide-by-zero and signed overflow.
module div (
  input logic   clk,
  input logic   reset_n,
  div_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  state_e      r_state, w_state_next;
  logic [4:0]  r_cnt;
  logic [31:0] r_rem, r_quo, r_divisor;
  logic        r_neg_q, r_neg_r, r_is_rem, r_div_zero;

  logic [31:0] w_a, w_b, w_abs_a, w_abs_b;
  logic        w_is_div, w_signed, w_is_rem, w_div_zero, w_early;
  logic        w_load, w_hold;
  logic [31:0] w_result, w_early_val, w_quo_fin, w_rem_fin;
  logic [32:0] w_shifted, w_diff;

  assign w_a = bus.first_operand_i;
  assign w_b = bus.second_operand_i;

  always_comb begin
    w_is_div   = (bus.instruction_operation_i == DIV)  || (bus.instruction_operation_i == DIVU) ||
                 (bus.instruction_operation_i == REM)  || (bus.instruction_operation_i == REMU);
    w_signed   = (bus.instruction_operation_i == DIV)  || (bus.instruction_operation_i == REM);
    w_is_rem   = (bus.instruction_operation_i == REM)  || (bus.instruction_operation_i == REMU);
    w_div_zero = (w_b == 32'd0);
    w_abs_a    = (w_signed && w_a[31]) ? -w_a : w_a;
    w_abs_b    = (w_signed && w_b[31]) ? -w_b : w_b;
`ifdef DIV_EARLY_OUT_EN
    w_early     = w_is_div && (w_div_zero ||
                  (w_signed && (w_a == 32'h8000_0000) && (w_b == 32'hFFFF_FFFF)));
    w_early_val = w_div_zero ? (w_is_rem ? w_a : 32'hFFFF_FFFF)
                             : (w_is_rem ? 32'd0 : 32'h8000_0000);
`else
    w_early     = 1'b0;
    w_early_val = 32'd0;
`endif
  end

  // With divisor 0 every trial subtract succeeds, so rem ends as |dividend| and the sign fix restores it raw.
  assign w_shifted = {r_rem, r_quo[31]};
  assign w_diff    = w_shifted - {1'b0, r_divisor};
  assign w_quo_fin = r_div_zero ? 32'hFFFF_FFFF : (r_neg_q ? -r_quo : r_quo);
  assign w_rem_fin = r_neg_r ? -r_rem : r_rem;

  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_hold       = 1'b0;
    w_result     = 32'd0;
    case (r_state)
      IDLE: begin
        if (w_is_div) begin
          if (w_early) begin
            w_result = w_early_val;
          end else begin
            w_hold       = 1'b1;
            w_load       = 1'b1;
            w_state_next = CALC;
          end
        end
      end
      CALC: begin
        w_hold = 1'b1;
        if (r_cnt == 5'd31) w_state_next = DONE;
      end
      DONE: begin
        w_result     = r_is_rem ? w_rem_fin : w_quo_fin;
        w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Outputs are gated by reset so a mid-operation reset silences them before any clock edge.
  assign bus.hold_o       = reset_n & w_hold;
  assign bus.div_result_o = reset_n ? w_result : 32'd0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt      <= 5'd0;
      r_rem      <= 32'd0;
      r_quo      <= 32'd0;
      r_divisor  <= 32'd0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_is_rem   <= 1'b0;
      r_div_zero <= 1'b0;
    end else if (w_load) begin
      r_cnt      <= 5'd0;
      r_rem      <= 32'd0;
      r_quo      <= w_abs_a;
      r_divisor  <= w_abs_b;
      r_neg_q    <= w_signed & (w_a[31] ^ w_b[31]);
      r_neg_r    <= w_signed & w_a[31];
      r_is_rem   <= w_is_rem;
      r_div_zero <= w_div_zero;
    end else if (r_state == CALC) begin
      r_cnt <= r_cnt + 5'd1;
      if (!w_diff[32]) begin
        r_rem <= w_diff[31:0];
        r_quo <= {r_quo[30:0], 1'b1};
      end else begin
        r_rem <= w_shifted[31:0];
        r_quo <= {r_quo[30:0], 1'b0};
      end
    end
  end
endmodule

// File: doc/div.md
# div

Iterative radix-2 integer divider for the RV32M division group (DIV, DIVU, REM, REMU). It sits in the execute stage beside the multiplier, on the same operand and operation inputs. It stalls the pipeline through `hold_o` while it iterates one quotient bit per cycle. It then returns the quotient or remainder with RISC-V-defined results for divide-by-zero and signed overflow.

## Interface
- Parameters: none.
- `clk`  in  1  core clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `first_operand_i`  in  32  dividend (rs1).
- `second_operand_i`  in  32  divisor (rs2).
- `instruction_operation_i`  in  `iType_e`  decoded operation. Only DIV, DIVU, REM and REMU start the block.
- `hold_o`  out  1  stall request to the pipeline.
- `div_result_o`  out  32  result. Valid only in the cycle where an operation completes.

## Operation
- The pipeline keeps operands and operation stable while `hold_o`=1. The block still latches everything at start.
- Signed ops are DIV and REM. Unsigned ops are DIVU and REMU.
- At start, latch:
  - |dividend| and |divisor| (two's-complement magnitude; for signed ops only, else raw);
  - `neg_q` = sign_a XOR sign_b (signed ops only);
  - `neg_r` = sign_a (signed ops only);
  - `is_rem`.
- State machine:
  - IDLE: `start` = operation is DIV, DIVU, REM or REMU. On start, drive `hold_o`=1 combinationally in the same cycle, load the registers, clear the 5-bit counter, go to CALC. Otherwise `hold_o`=0 and stay in IDLE.
  - CALC: `hold_o`=1. Each cycle:
    - shifted = {rem[31:0], quo[31]};
    - diff = shifted − {1'b0, divisor} (33-bit);
    - if diff[32]=0: rem←diff, quo←{quo[30:0],1};
    - else: rem←shifted, quo←{quo[30:0],0}.
    - Counter increments. After the iteration at count 31, go to DONE.
  - DONE: `hold_o`=0 and `div_result_o` is driven. Next state is IDLE unconditionally.
- Result selection in DONE:
  - if divisor was 0: quotient = 0xFFFFFFFF, remainder = dividend (raw);
  - else quotient = neg_q ? −quo : quo, and remainder = neg_r ? −rem[31:0] : rem[31:0];
  - `div_result_o` = `is_rem` ? remainder : quotient.
- Overflow (DIV/REM, 0x80000000 ÷ 0xFFFFFFFF) falls out of the magnitude path: quotient 0x80000000, remainder 0.
- `div_result_o` = 0 in every cycle other than DONE or an early-out cycle.
- Non-divide operations in IDLE: no state change, `hold_o`=0, result 0.

## Timing
- Normal latency is 34 cycles:
  - start cycle (IDLE, hold=1);
  - 32 CALC cycles (hold=1);
  - DONE cycle (hold=0, result valid).
- The pipeline advances at the end of the DONE cycle. The next instruction appears in the following cycle while the block is in IDLE. A new divide then starts immediately, so back-to-back divides are separated by no idle cycles.
- Asynchronous reset, including mid-operation, forces:
  - state IDLE;
  - counter, rem, quo and flag registers to 0;
  - `hold_o`=0 and `div_result_o`=0.
- After reset deassertion, a divide on the inputs starts on the first clock edge.

## Configuration
- `DIV_EARLY_OUT_EN` defined: in IDLE, a divide with divisor 0, or a signed op with dividend 0x80000000 and divisor 0xFFFFFFFF, completes in one cycle.
  - `hold_o`=0 in that cycle, and `div_result_o` is driven combinationally with the special-case value.
  - State stays IDLE and no registers change.
- `DIV_EARLY_OUT_EN` undefined: these cases take the full 34 cycles. Results must be bit-identical to the defined case.

## Test plan
- DIVU 100 ÷ 7 → `hold_o` high from the start cycle through 32 CALC cycles; DONE cycle `div_result_o`=14. REMU on the same operands → 2.
- DIV 0xFFFFFFF9 (−7) ÷ 2 → 0xFFFFFFFD (−3). REM on the same operands → 0xFFFFFFFF (−1). DIV 7 ÷ 0xFFFFFFFE (−2) → 0xFFFFFFFD.
- Divide by zero with dividend 5: DIV → 0xFFFFFFFF, DIVU → 0xFFFFFFFF, REM → 5, REMU → 5. Latency is 1 cycle with `DIV_EARLY_OUT_EN` and 34 cycles without; values are identical in both builds.
- Overflow 0x80000000 ÷ 0xFFFFFFFF: DIV → 0x80000000, REM → 0. DIVU → 0, REMU → 0x80000000.
- Assert `reset_n`=0 in the 10th CALC cycle → `hold_o`=0 and `div_result_o`=0 immediately. After release, DIVU 0xFFFFFFFF ÷ 0x10 → 0x0FFFFFFF.
- Back-to-back DIVU 1000 ÷ 10 then REMU 1000 ÷ 3 → 100, then 1, each with a 34-cycle latency and no idle cycle between them.
